// File: rtl/loopback_status_pack.sv
// Loopback link status: debounced link FSM, good/bad frame counters and sticky error bits packed into one word.
// Build with LOOPBACK_STATUS_TIMEOUT_EN defined to add the idle-timeout sticky bit (status_word[28]).
module loopback_status_pack #(
    parameter int DEBOUNCE_LEN = 1024,
    parameter int TIMEOUT_LEN  = 1048576
) (
    input  logic        user_clk,
    input  logic        user_rst,
    input  logic        link_raw,
    input  logic        rx_valid,
    input  logic        rx_eof,
    input  logic        rx_bad,
    input  logic        rx_overrun,
    input  logic        stat_clr,
    output logic [31:0] status_word
);

    typedef enum logic [1:0] {
        ST_DOWN      = 2'b00,
        ST_UP_PEND   = 2'b01,
        ST_UP        = 2'b10,
        ST_DOWN_PEND = 2'b11
    } link_state_t;

    // The cycle that leaves DOWN/UP already counts as the first stable cycle,
    // so the pending state exits when its counter has seen DEBOUNCE_LEN-2 more.
    localparam int          DB_LAST_INT = (DEBOUNCE_LEN > 1) ? DEBOUNCE_LEN - 2 : 0;
    localparam logic [15:0] DB_LAST     = 16'(DB_LAST_INT);
    localparam logic        DB_ONE      = (DEBOUNCE_LEN == 1);
    localparam logic [23:0] TO_LEN      = 24'(TIMEOUT_LEN);

    link_state_t r_state;
    link_state_t w_state_nxt;
    logic [15:0] r_stab_cnt;
    logic [15:0] w_stab_nxt;

    logic [15:0] r_good_cnt;
    logic [7:0]  r_bad_cnt;
    logic        r_sticky_ovr;
    logic        r_sticky_bad;
    logic        w_sticky_to;

    logic        w_eof_q;
    logic        w_good_ev;
    logic        w_bad_ev;
    logic        w_ovr_ev;
    logic [15:0] w_good_base;
    logic [7:0]  w_bad_base;
    logic [1:0]  w_state_code;

    assign w_eof_q     = rx_valid & rx_eof;
    assign w_good_ev   = w_eof_q & ~rx_bad;
    assign w_bad_ev    = w_eof_q & rx_bad;
    assign w_ovr_ev    = rx_valid & rx_overrun;
    assign w_good_base = stat_clr ? 16'd0 : r_good_cnt;
    assign w_bad_base  = stat_clr ? 8'd0 : r_bad_cnt;

    // Link FSM: state register
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_state    <= ST_DOWN;
            r_stab_cnt <= 16'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_stab_cnt <= w_stab_nxt;
        end
    end

    // Link FSM: next state and stability counter
    always_comb begin
        w_state_nxt = r_state;
        w_stab_nxt  = r_stab_cnt;
        case (r_state)
            ST_DOWN: begin
                if (link_raw) begin
                    if (DB_ONE) w_state_nxt = ST_UP;
                    else        w_state_nxt = ST_UP_PEND;
                end
            end
            ST_UP_PEND: begin
                if (!link_raw)                  w_state_nxt = ST_DOWN;
                else if (r_stab_cnt == DB_LAST) w_state_nxt = ST_UP;
                else                            w_stab_nxt  = r_stab_cnt + 16'd1;
            end
            ST_UP: begin
                if (!link_raw) begin
                    if (DB_ONE) w_state_nxt = ST_DOWN;
                    else        w_state_nxt = ST_DOWN_PEND;
                end
            end
            ST_DOWN_PEND: begin
                if (link_raw)                   w_state_nxt = ST_UP;
                else if (r_stab_cnt == DB_LAST) w_state_nxt = ST_DOWN;
                else                            w_stab_nxt  = r_stab_cnt + 16'd1;
            end
            default: w_state_nxt = ST_DOWN;
        endcase
        if (w_state_nxt != r_state) w_stab_nxt = 16'd0;
    end

    // Counters and sticky bits; an event in the same cycle as stat_clr survives the clear.
    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_good_cnt   <= 16'd0;
            r_bad_cnt    <= 8'd0;
            r_sticky_ovr <= 1'b0;
            r_sticky_bad <= 1'b0;
        end else begin
            r_good_cnt <= w_good_base + {15'd0, w_good_ev};
            if (w_bad_ev && (w_bad_base != 8'hFF)) r_bad_cnt <= w_bad_base + 8'd1;
            else                                   r_bad_cnt <= w_bad_base;
            r_sticky_ovr <= w_ovr_ev | (r_sticky_ovr & ~stat_clr);
            r_sticky_bad <= w_bad_ev | (r_sticky_bad & ~stat_clr);
        end
    end

`ifdef LOOPBACK_STATUS_TIMEOUT_EN
    logic [23:0] r_idle_cnt;
    logic        r_sticky_to;
    logic        w_to_hit;

    // Sticky sets only on the step that brings the idle count to TIMEOUT_LEN; the count then holds.
    assign w_to_hit = (r_state == ST_UP) && !w_eof_q && (r_idle_cnt == TO_LEN - 24'd1);

    always_ff @(posedge user_clk) begin
        if (user_rst) begin
            r_idle_cnt  <= 24'd0;
            r_sticky_to <= 1'b0;
        end else begin
            if ((r_state != ST_UP) || w_eof_q) r_idle_cnt <= 24'd0;
            else if (r_idle_cnt != TO_LEN)     r_idle_cnt <= r_idle_cnt + 24'd1;
            r_sticky_to <= w_to_hit | (r_sticky_to & ~stat_clr);
        end
    end

    assign w_sticky_to = r_sticky_to;
`else
    logic w_unused_timeout;
    assign w_unused_timeout = ^TO_LEN;
    assign w_sticky_to      = 1'b0;
`endif

    assign w_state_code = r_state;
    assign status_word  = {w_state_code[1], r_sticky_ovr, r_sticky_bad, w_sticky_to,
                           w_state_code, 2'b00, r_bad_cnt, r_good_cnt};

endmodule
